seg7_scroll_display: RTL and testbench
======================================

Name: seg7_scroll_display

Overview:
Parametrised successor to the single-digit character display. Accepts ASCII characters over a valid/ready stream into a character FIFO and scrolls them right-to-left across NUM_DIGITS seven-segment digits. Drives all digits by time-multiplexing one shared segment bus. Sits between the CPU's memory-mapped display register and the board's seven-segment pins.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (2..8)
FIFO_DEPTH, 16, character FIFO entries (power of 2, >=2)
REFRESH_DIV, 100000, clk cycles each digit stays selected (>=1)
SCROLL_DIV, 50000000, clk cycles between scroll ticks (>=2)
SEG_ACTIVE_LOW, 0, 1 inverts segments_o polarity

Ports:
clk_i  in  1  system clock
rst_ni  in  1  asynchronous active-low reset
char_i  in  8  ASCII character
charValid_i  in  1  char_i valid
charReady_o  out  1  FIFO can accept (=!full)
clear_i  in  1  synchronous flush of FIFO and digit buffer
level_o  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
digitSel_o  out  NUM_DIGITS  one-hot digit enable, active-low
segments_o  out  7  {g,f,e,d,c,b,a}, 1=lit when SEG_ACTIVE_LOW=0

Behaviour:
- One clock; reset is asynchronous and active-low. All state clears on rst_ni low regardless of clock, including mid-scroll and mid-push.
- Reset values: FIFO empty, level_o=0, charReady_o=1, digit buffer all 0x20, digit index 0, digitSel_o=~1 (digit 0 on), segments_o=blank (7'h00, or 7'h7F if SEG_ACTIVE_LOW), refresh and scroll counters 0.
- Push: when charValid_i && charReady_o && !clear_i at a rising edge. level_o updates the next cycle. Data must stay stable while valid && !ready.
- Full: charReady_o=0 when level_o==FIFO_DEPTH. Push while full is ignored; no overwrite.
- Scroll tick: pulses one cycle when the scroll counter reaches SCROLL_DIV-1, then the counter wraps to 0.
- On a tick with the FIFO non-empty: pop one char, shift the buffer left (digit NUM_DIGITS-1 drops), and put the new char in digit 0 (rightmost).
- On a tick with the FIFO empty: buffer holds and there is no underflow.
- Simultaneous push and pop on the same edge: level unchanged. This is legal even when full, because the pop frees a slot; charReady_o still reflects the pre-edge full state.
- Pointers wrap modulo FIFO_DEPTH.
- clear_i: on that edge the FIFO is emptied, the buffer is set to 0x20 and the scroll counter goes to 0. A push on the same edge is dropped. Clear has priority over both push and pop. The refresh counter is unaffected.
- Refresh: the counter wraps at REFRESH_DIV-1, then the digit index increments modulo NUM_DIGITS.
- digitSel_o and segments_o are both registered and change on the same edge, one cycle after the index changes. No cycle may show a glitch where segments_o belongs to one digit and digitSel_o to another.
- Decoder (active-high):
  - '0'-'9': 3F 06 5B 4F 66 6D 7D 07 7F 6F
  - 'A'/'a' 77; 'B'/'b' 7C; 'C'/'c' 39; 'D'/'d' 5E; 'E'/'e' 79; 'F'/'f' 71
  - 'H'/'h' 74; 'L'/'l' 38; 'O'/'o' 5C; 'R'/'r' 50
  - 0x20 and 0xA0: 00
  - any other code: 40 (dash)
- SEG_ACTIVE_LOW=1 inverts the final decoded value.

Optional Feature:
- Macro BLINK_EN.
- Defined: adds input blink_i (1 bit) and a blink-phase flop, reset 0, which toggles on every scroll tick. While blink_i=1 and phase=1, segments_o is blank; digitSel_o keeps cycling and the FIFO/scroll behaviour is unchanged. Clear resets the phase to 0.
- Undefined: no blink_i port, no phase flop, never blanks.

Test Plan:
- Reset: hold rst_ni=0 with clk running -> segments_o=00, digitSel_o=4'b1110, charReady_o=1, level_o=0. Release -> buffer shows blank on all 4 digits.
- Params NUM_DIGITS=4, FIFO_DEPTH=4, REFRESH_DIV=2, SCROLL_DIV=8:
  - Push "1","2","3","4", then charValid_i held with "5" -> level_o reaches 4, charReady_o=0, "5" is not accepted until the first scroll pop.
  - After 4 ticks, scan the digits -> digit3..0 segments = 06,5B,4F,66, each digitSel_o low for exactly 2 cycles in order 0,1,2,3.
- Empty FIFO over several ticks -> buffer frozen, level_o stays 0, no spurious shift.
- Push on the exact scroll-tick edge with level_o=4 -> level_o stays 4 and the popped char appears in digit 0.
- clear_i asserted together with charValid_i="A" -> next cycle level_o=0, all digits show 00, "A" is never displayed.
- Decode: chars 0xA0, 'h', '?' reach digit 0 -> segments 00, 74, 40. With SEG_ACTIVE_LOW=1 -> 7F, 0B, 3F.
- BLINK_EN build, blink_i=1 -> segments blank for one full scroll period and lit for the next, alternating.
- Async reset: assert rst_ni mid-scroll -> all outputs return to reset values before the next clk edge.

Source files
------------

// File: rtl/seg7_scroll_display.sv
// Scrolling multi-digit seven-segment display: ASCII stream -> character FIFO -> digit buffer -> multiplexed segment bus.
// Optional macro BLINK_EN adds blink_i, which blanks the segments on alternate scroll periods.
module seg7_scroll_display #(
  parameter int NUM_DIGITS     = 4,
  parameter int FIFO_DEPTH     = 16,
  parameter int REFRESH_DIV    = 100000,
  parameter int SCROLL_DIV     = 50000000,
  parameter int SEG_ACTIVE_LOW = 0
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [7:0]                    char_i,
  input  logic                          charValid_i,
  output logic                          charReady_o,
  input  logic                          clear_i,
`ifdef BLINK_EN
  input  logic                          blink_i,
`endif
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic [NUM_DIGITS-1:0]         digitSel_o,
  output logic [6:0]                    segments_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int SW = $clog2(SCROLL_DIV);

  localparam logic [LW-1:0] FULL_LVL     = LW'(FIFO_DEPTH);
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [SW-1:0] SCROLL_LAST  = SW'(SCROLL_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST     = IW'(NUM_DIGITS - 1);
  localparam logic [6:0]    SEG_MASK     = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

  logic [7:0]            fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic [SW-1:0]         scroll_cnt_q, scroll_cnt_d;
  logic [RW-1:0]         refresh_cnt_q, refresh_cnt_d;
  logic [IW-1:0]         digit_idx_q, digit_idx_d;
  logic [7:0]            disp_q [NUM_DIGITS];
  logic [7:0]            disp_d [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] digit_sel_q, digit_sel_d;
  logic [6:0]            seg_q, seg_d;

  logic       full, empty, tick, pop, push, blank;
  logic [7:0] rd_data;

  function automatic logic [6:0] decode_char(input logic [7:0] c);
    logic [6:0] s;
    case (c)
      8'h30: s = 7'h3F;
      8'h31: s = 7'h06;
      8'h32: s = 7'h5B;
      8'h33: s = 7'h4F;
      8'h34: s = 7'h66;
      8'h35: s = 7'h6D;
      8'h36: s = 7'h7D;
      8'h37: s = 7'h07;
      8'h38: s = 7'h7F;
      8'h39: s = 7'h6F;
      8'h41, 8'h61: s = 7'h77;
      8'h42, 8'h62: s = 7'h7C;
      8'h43, 8'h63: s = 7'h39;
      8'h44, 8'h64: s = 7'h5E;
      8'h45, 8'h65: s = 7'h79;
      8'h46, 8'h66: s = 7'h71;
      8'h48, 8'h68: s = 7'h74;
      8'h4C, 8'h6C: s = 7'h38;
      8'h4F, 8'h6F: s = 7'h5C;
      8'h52, 8'h72: s = 7'h50;
      8'h20, 8'hA0: s = 7'h00;
      default:      s = 7'h40;
    endcase
    return s;
  endfunction

  assign full    = (level_q == FULL_LVL);
  assign empty   = (level_q == '0);
  assign tick    = (scroll_cnt_q == SCROLL_LAST);
  assign pop     = tick & ~empty & ~clear_i;
  // A pop on the same edge frees a slot, so a full FIFO may still take a push then.
  assign push    = charValid_i & (~full | pop) & ~clear_i;
  assign rd_data = fifo_mem[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= char_i;
    end
  end

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    level_d       = level_q;
    scroll_cnt_d  = scroll_cnt_q + SW'(1);
    refresh_cnt_d = refresh_cnt_q + RW'(1);
    digit_idx_d   = digit_idx_q;
    disp_d        = disp_q;

    if (tick) begin
      scroll_cnt_d = '0;
    end

    if (clear_i) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      level_d      = '0;
      scroll_cnt_d = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        disp_d[i] = 8'h20;
      end
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
        for (int i = 1; i < NUM_DIGITS; i++) begin
          disp_d[i] = disp_q[i-1];
        end
        disp_d[0] = rd_data;
      end
      case ({push, pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end

    if (refresh_cnt_q == REFRESH_LAST) begin
      refresh_cnt_d = '0;
      digit_idx_d   = (digit_idx_q == IDX_LAST) ? '0 : digit_idx_q + IW'(1);
    end
  end

  // Select and segments are both registered from the same index so they never disagree.
  always_comb begin
    digit_sel_d = ~(NUM_DIGITS'(1) << digit_idx_q);
    seg_d       = blank ? SEG_MASK : (decode_char(disp_q[digit_idx_q]) ^ SEG_MASK);
  end

`ifdef BLINK_EN
  logic blink_phase_q, blink_phase_d;

  always_comb begin
    blink_phase_d = blink_phase_q;
    if (clear_i) begin
      blink_phase_d = 1'b0;
    end else if (tick) begin
      blink_phase_d = ~blink_phase_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      blink_phase_q <= 1'b0;
    end else begin
      blink_phase_q <= blink_phase_d;
    end
  end

  assign blank = blink_i & blink_phase_q;
`else
  assign blank = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      scroll_cnt_q  <= '0;
      refresh_cnt_q <= '0;
      digit_idx_q   <= '0;
      digit_sel_q   <= ~NUM_DIGITS'(1);
      seg_q         <= SEG_MASK;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        disp_q[i] <= 8'h20;
      end
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      scroll_cnt_q  <= scroll_cnt_d;
      refresh_cnt_q <= refresh_cnt_d;
      digit_idx_q   <= digit_idx_d;
      digit_sel_q   <= digit_sel_d;
      seg_q         <= seg_d;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        disp_q[i] <= disp_d[i];
      end
    end
  end

  assign charReady_o = ~full;
  assign level_o     = level_q;
  assign digitSel_o  = digit_sel_q;
  assign segments_o  = seg_q;

endmodule

// File: tb/tb_seg7_scroll_display.sv
// Bench for seg7_scroll_display: NUM_DIGITS=4, FIFO_DEPTH=4, REFRESH_DIV=2, SCROLL_DIV=8, with an
// active-high and an active-low instance driven by the same stimulus.
module tb_seg7_scroll_display;

  logic       clk, rst_n, valid, clear;
  logic [7:0] ch;
`ifdef BLINK_EN
  logic       blink;
`endif
  logic       ready_a, ready_b;
  logic [2:0] level_a, level_b;
  logic [3:0] dsel_a, dsel_b;
  logic [6:0] seg_a, seg_b;

  int vectors = 0;
  int miscompares = 0;

  seg7_scroll_display #(
    .NUM_DIGITS(4), .FIFO_DEPTH(4), .REFRESH_DIV(2), .SCROLL_DIV(8), .SEG_ACTIVE_LOW(0)
  ) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .char_i(ch), .charValid_i(valid), .charReady_o(ready_a),
    .clear_i(clear),
`ifdef BLINK_EN
    .blink_i(blink),
`endif
    .level_o(level_a), .digitSel_o(dsel_a), .segments_o(seg_a)
  );

  seg7_scroll_display #(
    .NUM_DIGITS(4), .FIFO_DEPTH(4), .REFRESH_DIV(2), .SCROLL_DIV(8), .SEG_ACTIVE_LOW(1)
  ) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .char_i(ch), .charValid_i(valid), .charReady_o(ready_b),
    .clear_i(clear),
`ifdef BLINK_EN
    .blink_i(blink),
`endif
    .level_o(level_b), .digitSel_o(dsel_b), .segments_o(seg_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: accepted characters are queued as they are driven and retired on each scroll pop.
  logic [7:0] m_q[$];
  int         m_sc;
  bit         m_tick, m_pop, m_acc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_sc = 0;
    end else if (clear) begin
      m_q.delete();
      m_sc = 0;
    end else begin
      m_tick = (m_sc == 7);
      m_pop  = m_tick && (m_q.size() > 0);
      m_acc  = valid && ((m_q.size() < 4) || m_pop);
      if (m_pop) void'(m_q.pop_front());
      if (m_acc) m_q.push_back(ch);
      m_sc = m_tick ? 0 : m_sc + 1;
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("level_o", level_a, m_q.size());
      chk("charReady_o", ready_a, m_q.size() != 4);
    end
  end

  // Align on the digit-3 -> digit-0 select change, then check one full scan of 8 cycles.
  task automatic scan(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                      input logic [6:0] s2, input logic [6:0] s3);
    logic [6:0] exp_s [4];
    logic [6:0] exp_inv;
    logic [3:0] prev, exp_sel;
    logic [6:0] got [4];
    int         w, d;
    exp_s[0] = s0; exp_s[1] = s1; exp_s[2] = s2; exp_s[3] = s3;
    prev = dsel_a;
    w = 0;
    while (!(dsel_a == 4'b1110 && prev == 4'b0111)) begin
      prev = dsel_a;
      @(negedge clk);
      w++;
      if (w > 24) begin
        vectors++;
        miscompares++;
        $display("FAIL %s_align: digitSel_o never cycled, last %b", tag, dsel_a);
        return;
      end
    end
    for (int c = 0; c < 8; c++) begin
      if (c > 0) @(negedge clk);
      d = c / 2;
      exp_sel = ~(4'b0001 << d);
      exp_inv = ~exp_s[d];
      got[d]  = seg_a;
      chk({tag, "_sel"}, dsel_a, exp_sel);
      chk({tag, "_seg"}, seg_a, exp_s[d]);
      chk({tag, "_seg_lo"}, seg_b, exp_inv);
    end
    $display("scan %s: digit3..0 = %h %h %h %h", tag, got[3], got[2], got[1], got[0]);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  typedef struct {
    logic [7:0] c;
    logic [6:0] seg;
  } dec_vec_t;

  dec_vec_t dv [10];
  bit       seen;

  initial begin
    dv[0] = '{8'hA0, 7'h00};
    dv[1] = '{8'h68, 7'h74};
    dv[2] = '{8'h3F, 7'h40};
    dv[3] = '{8'h30, 7'h3F};
    dv[4] = '{8'h39, 7'h6F};
    dv[5] = '{8'h45, 7'h79};
    dv[6] = '{8'h72, 7'h50};
    dv[7] = '{8'h62, 7'h7C};
    dv[8] = '{8'h4C, 7'h38};
    dv[9] = '{8'h64, 7'h5E};

    rst_n = 1'b0; valid = 1'b0; clear = 1'b0; ch = 8'h00;
`ifdef BLINK_EN
    blink = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_seg", seg_a, 7'h00);
    chk("rst_seg_lo", seg_b, 7'h7F);
    chk("rst_sel", dsel_a, 4'b1110);
    chk("rst_ready", ready_a, 1'b1);
    chk("rst_level", level_a, 3'd0);
    rst_n = 1'b1;
    scan("reset_blank", 7'h00, 7'h00, 7'h00, 7'h00);

    // Fill to full, hold "5" against backpressure, accept it on the pop edge.
    do_clear();
    for (int k = 1; k <= 4; k++) begin
      valid = 1'b1;
      ch = 8'h30 + 8'(k);
      @(negedge clk);
    end
    chk("full_level", level_a, 3'd4);
    chk("full_ready", ready_a, 1'b0);
    ch = "5";
    repeat (3) @(negedge clk);
    chk("hold_level", level_a, 3'd4);
    chk("hold_ready", ready_a, 1'b0);
    @(negedge clk);
    chk("pushpop_level", level_a, 3'd4);
    valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (!seen && dsel_a == 4'b1110) begin
        chk("first_pop_digit0", seg_a, 7'h06);
        seen = 1'b1;
      end
    end
    if (!seen) begin
      vectors++;
      miscompares++;
      $display("FAIL first_pop_digit0: digit 0 never selected");
    end
    repeat (27) @(negedge clk);
    chk("drained_level", level_a, 3'd0);
    scan("scroll_2345", 7'h6D, 7'h66, 7'h4F, 7'h5B);
    repeat (30) @(negedge clk);
    scan("frozen_2345", 7'h6D, 7'h66, 7'h4F, 7'h5B);

    clear = 1'b1; valid = 1'b1; ch = "A";
    @(negedge clk);
    clear = 1'b0; valid = 1'b0;
    chk("clear_level", level_a, 3'd0);
    repeat (12) @(negedge clk);
    scan("clear_blank", 7'h00, 7'h00, 7'h00, 7'h00);

    for (int i = 0; i < 10; i++) begin
      do_clear();
      valid = 1'b1;
      ch = dv[i].c;
      @(negedge clk);
      valid = 1'b0;
      repeat (9) @(negedge clk);
      $display("decode vector %0d: char %h", i, dv[i].c);
      scan($sformatf("decode_%0d", i), dv[i].seg, 7'h00, 7'h00, 7'h00);
    end

    do_clear();
    for (int k = 1; k <= 4; k++) begin
      valid = 1'b1;
      ch = 8'h30 + 8'(k);
      @(negedge clk);
    end
    valid = 1'b0;
    repeat (30) @(negedge clk);
    scan("scroll_1234", 7'h66, 7'h4F, 7'h5B, 7'h06);

`ifdef BLINK_EN
    blink = 1'b1;
    do_clear();
    valid = 1'b1;
    ch = "8";
    @(negedge clk);
    valid = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      chk("blink_off", seg_a, 7'h00);
      chk("blink_off_lo", seg_b, 7'h7F);
      @(negedge clk);
    end
    for (int i = 0; i < 8; i++) begin
      chk("blink_on", seg_a, (dsel_a == 4'b1110) ? 7'h7F : 7'h00);
      @(negedge clk);
    end
    $display("blink sequence done");
    blink = 1'b0;
`endif

    // Asynchronous reset in the middle of a scroll period with characters pending.
    valid = 1'b1;
    ch = "7";
    @(negedge clk);
    ch = "8";
    @(negedge clk);
    valid = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_seg", seg_a, 7'h00);
    chk("async_seg_lo", seg_b, 7'h7F);
    chk("async_sel", dsel_a, 4'b1110);
    chk("async_ready", ready_a, 1'b1);
    chk("async_level", level_a, 3'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
